// File: rtl/logic_unit_arbiter.sv
// Shares one registered WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND)
// between four requesters under round-robin arbitration. The winner's
// operands and opcode are captured at grant time. The result is returned
// with a one-cycle done pulse. Each operation takes exactly three cycles.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   req     per-requester level-sensitive request
//   op_a    operand A, requester i at [i*WIDTH +: WIDTH]
//   op_b    operand B, same packing as op_a
//   op_sel  opcode, requester i at [2i +: 2]: 00 AND, 01 OR, 10 XOR, 11 NAND
//   grant   one-hot grant to the current owner, zero when idle
//   result  result of the most recent completed operation
//   done    one-hot, one-cycle completion pulse to the owner
//   busy    high whenever the unit is not idle
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   op_a,
  input  logic [4*WIDTH-1:0]   op_b,
  input  logic [7:0]           op_sel,
  output logic [3:0]           grant,
  output logic [WIDTH-1:0]     result,
  output logic [3:0]           done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned NREQ = 4;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       win_q, win_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       done_q, done_d;

  // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself.
  logic [1:0] win_c;
  logic       found_c;
  logic [1:0] idx_c;

  always_comb begin
    win_c   = 2'd0;
    found_c = 1'b0;
    idx_c   = 2'd0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx_c = ptr_q + 2'(off);
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  // Bitwise function of the latched operands.
  logic [WIDTH-1:0] func_c;

  always_comb begin
    func_c = '0;
    unique case (sel_q)
      2'b00:   func_c = a_q & b_q;
      2'b01:   func_c = a_q | b_q;
      2'b10:   func_c = a_q ^ b_q;
      default: func_c = ~(a_q & b_q);
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    grant_d  = grant_q;
    done_d   = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (found_c) begin
          win_d   = win_c;
          grant_d = 4'b0001 << win_c;
          a_d     = op_a[32'(win_c) * WIDTH +: WIDTH];
          b_d     = op_b[32'(win_c) * WIDTH +: WIDTH];
          sel_d   = op_sel[32'(win_c) * 2 +: 2];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = func_c;
        done_d   = 4'b0001 << win_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done_d  = 4'b0000;
        grant_d = 4'b0000;
        ptr_d   = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd3;
      win_q    <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 2'd0;
      result_q <= '0;
      grant_q  <= 4'b0000;
      done_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed steps and random
// traffic are compared each cycle against a transaction-level reference model.
module tb_logic_unit_arbiter;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] op_a;
  logic [4*WIDTH-1:0] op_b;
  logic [7:0]         op_sel;
  logic [3:0]         grant;
  logic [WIDTH-1:0]   result;
  logic [3:0]         done;
  logic               busy;

  int total = 0;
  int bad   = 0;

  // Reference model. It tracks the last winner, the cycles elapsed since the
  // current grant, and the result of the operation captured at grant time.
  int               m_last;
  int               m_age;
  int               m_win;
  logic [WIDTH-1:0] m_pend;
  logic [3:0]       m_grant;
  logic [3:0]       m_done;
  logic [WIDTH-1:0] m_result;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op_a   (op_a),
    .op_b   (op_b),
    .op_sel (op_sel),
    .grant  (grant),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input int code);
    case (code)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, update the model from the inputs seen at that
  // edge, then compare all outputs shortly after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_last = 3; m_age = 0; m_grant = 0; m_done = 0; m_result = 0;
    end else if (m_age == 0) begin
      if (req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (m_last + k) % 4;
          if (req[i]) begin
            m_win = i;
            break;
          end
        end
        m_pend  = apply_op(op_a[m_win*WIDTH +: WIDTH], op_b[m_win*WIDTH +: WIDTH],
                           int'(op_sel[m_win*2 +: 2]));
        m_grant = 4'(1 << m_win);
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_result = m_pend;
      m_done   = 4'(1 << m_win);
      m_age    = 2;
    end else begin
      m_grant = 0;
      m_done  = 0;
      m_last  = m_win;
      m_age   = 0;
    end
    #1;
    check("grant",  32'(grant),  32'(m_grant));
    check("done",   32'(done),   32'(m_done));
    check("result", 32'(result), 32'(m_result));
    check("busy",   32'(busy),   32'(m_age != 0));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int i, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [1:0] s);
    op_a[i*WIDTH +: WIDTH] = a;
    op_b[i*WIDTH +: WIDTH] = b;
    op_sel[i*2 +: 2]       = s;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; op_a = '0; op_b = '0; op_sel = '0;
    m_last = 3; m_age = 0; m_win = 0; m_pend = 0;
    m_grant = 0; m_done = 0; m_result = 0;

    // Reset state.
    ticks(2);
    rst = 1'b0;

    // Requester 0 ANDs F0 with 3C.
    load(0, 8'hF0, 8'h3C, 2'b00);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    ticks(3);
    check("and_result", 32'(result), 32'h30);

    // Requester 2 issues OR, XOR, NAND back to back.
    load(2, 8'hF0, 8'h3C, 2'b01); req = 4'b0100; tick(); req = 4'b0000; ticks(2);
    check("or_result", 32'(result), 32'hFC);
    load(2, 8'hF0, 8'h3C, 2'b10); req = 4'b0100; tick(); req = 4'b0000; ticks(2);
    check("xor_result", 32'(result), 32'hCC);
    load(2, 8'hF0, 8'h3C, 2'b11); req = 4'b0100; tick(); req = 4'b0000; ticks(2);
    check("nand_result", 32'(result), 32'hCF);

    // All four requesters held from reset: grants rotate every 3 cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) load(i, 8'(8'h11 * (i + 1)), 8'h5A, 2'(i));
    req = 4'b1111;
    ticks(15);

    // Requester 1 served last, then 0 and 1 both request: 0 then 1.
    req = 4'b0000; ticks(3);
    req = 4'b0010; tick(); req = 4'b0000; ticks(2);
    req = 4'b0011; tick();
    check("rr_after_1", 32'(grant), 32'h1);
    ticks(3);
    check("rr_next", 32'(grant), 32'h2);
    req = 4'b0000; ticks(2);

    // Drop req and change operands after the grant: latched values still used.
    load(0, 8'hA5, 8'h0F, 2'b10);
    req = 4'b0001; tick();
    req = 4'b0000; op_a[WIDTH-1:0] = 8'h00; tick();
    check("latched_done", 32'(done), 32'h1);
    check("latched_result", 32'(result), 32'hAA);
    ticks(2);

    // Reset during EXEC aborts without done; ptr returns to 3.
    req = 4'b1001; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_done", 32'(done), 32'h0);
    tick();
    check("post_reset_grant", 32'(grant), 32'h1);
    req = 4'b0000; ticks(3);

    // Random traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      rst    = ($urandom_range(0, 59) == 0);
      req    = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'b0000;
      op_a   = 32'($urandom);
      op_b   = 32'($urandom);
      op_sel = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
